matrix_result_streamer: RTL and testbench
=========================================

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 Parameter M, default 2: number of rows in the result matrix.
REQ-002 Parameter N, default 2: number of columns in the result matrix.
REQ-003 Parameter DATA_W, default 32: element width, signed two's-complement fixed-point; the streamer does no arithmetic on elements.
REQ-004 Derived widths SHALL be RW = max(1, clog2(M)) and CW = max(1, clog2(N)).
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 load_valid  in  1  a result matrix is presented on load_data.
REQ-008 load_ready  out  1  the streamer can accept a matrix.
REQ-009 load_data  in  M*N*DATA_W  flat row-major matrix; element k occupies bits [k*DATA_W +: DATA_W], with k = i*N + j.
REQ-010 abort  in  1  synchronous flush of any stream in progress.
REQ-011 out_valid  out  1  out_data holds a valid element.
REQ-012 out_ready  in  1  the downstream consumer accepts the element.
REQ-013 out_data  out  DATA_W  current element.
REQ-014 out_row  out  RW  row index of the current element.
REQ-015 out_col  out  CW  column index of the current element.
REQ-016 out_last  out  1  the current element is the final one (k = M*N-1).
REQ-017 busy  out  1  high whenever the state is STREAM.

Function
REQ-018 The state machine SHALL have exactly two states, IDLE and STREAM.
REQ-019 In IDLE: load_ready=1, out_valid=0.
REQ-020 In STREAM: load_ready=0.
REQ-021 A load handshake (load_valid & load_ready) in IDLE SHALL capture load_data into an internal buffer, set the index to k=0, and enter STREAM on the same edge.
REQ-022 out_valid SHALL be 1 in the first cycle of STREAM, presenting element 0; load-to-first-valid latency is 1 cycle.
REQ-023 A beat completes on out_valid & out_ready and SHALL advance k by 1, scanning j fastest, then i.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-025 out_ready=1 every cycle SHALL produce one beat per cycle, so M*N beats occupy M*N consecutive cycles.
REQ-026 Completion of the beat with out_last=1 SHALL return the state to IDLE; load_ready becomes 1 in the next cycle.
REQ-027 There SHALL be no load/stream overlap: a new matrix is accepted only once the previous stream is fully drained.
REQ-028 load_valid during STREAM SHALL be ignored and SHALL NOT corrupt the buffer.
REQ-029 abort=1 in STREAM SHALL force IDLE on the next edge and drop remaining elements; a beat handshaking in that same cycle counts as delivered.
REQ-030 abort has priority over out_ready.
REQ-031 abort=1 in IDLE SHALL have no effect; it does not block a simultaneous load.
REQ-032 When out_valid=0, out_data, out_row, out_col and out_last SHALL read as 0.
REQ-033 For M=N=1, the single beat SHALL carry out_last=1 and out_row=out_col=0.

Reset
REQ-034 On rst_n=0, asynchronously: state=IDLE, k=0, buffer cleared to 0.
REQ-035 Output values during reset: out_valid=0, out_last=0, out_data=0, out_row=0, out_col=0, busy=0, load_ready=1.
REQ-036 Reset asserted mid-stream SHALL discard the stream; no beat appears after reset deasserts until a new load.

Structure
REQ-037 A shared package SHALL hold the state enum (IDLE, STREAM) and a function computing the max(1, clog2(x)) index width.
REQ-038 The package SHALL be reused by the future matrix loader and the multiplier.
REQ-039 One sub-module is natural: matrix_index_counter, a row/column counter with enable, clear and a last-flag output.

Verification
REQ-040 2x2 matrix [1,2,3,4] loaded, out_ready=1 -> beats at cycles 1-4 with data 1,2,3,4, (row,col) = (0,0),(0,1),(1,0),(1,1), out_last only on beat 4, load_ready=1 at cycle 5.
REQ-041 2x2 matrix [5,6,7,8] with out_ready low in cycles 1-3 -> element 5 held stable with out_valid=1 for 3 cycles, then 5,6,7,8 delivered in order.
REQ-042 During the stream of [1,2,3,4], load_valid is pulsed with [9,9,9,9] -> the beats remain 1,2,3,4 and load_ready stays 0 until the drain completes.
REQ-043 rst_n pulled low after beat 2 of 4 -> all outputs reach reset values immediately and no further beats appear; a subsequent load of [1,2,3,4] restarts from element 1.
REQ-044 abort asserted together with the handshake of beat 2 in a 3x2 stream -> exactly 2 beats delivered, state IDLE and load_ready=1 on the next cycle.
REQ-045 M=N=1 load of [-3] -> one beat carrying data -3, out_last=1, row=col=0.

Source files
------------

// File: rtl/matrix_result_streamer_pkg.sv
// Shared definitions for the matrix datapath: streamer state encoding and
// index-width helper reused by the loader and multiplier.
package matrix_result_streamer_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_e;

    // Index width for a dimension of x entries, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/matrix_result_streamer_index_counter.sv
// Row/column scan counter (column fastest) with clear, enable and a
// registered flag marking the final element of the matrix.
module matrix_index_counter
    import matrix_result_streamer_pkg::*;
#(
    parameter int unsigned M  = 2,
    parameter int unsigned N  = 2,
    parameter int unsigned RW = idx_width(M),
    parameter int unsigned CW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic          last_o,
    output logic [RW-1:0] row_nxt_c_o,
    output logic [CW-1:0] col_nxt_c_o,
    output logic          last_nxt_c_o
);

    localparam logic [RW-1:0] ROW_MAX      = RW'(M - 1);
    localparam logic [CW-1:0] COL_MAX      = CW'(N - 1);
    localparam logic          LAST_AT_ZERO = (M == 1) && (N == 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_q, last_d;

    // Clear wins over enable; the next index is exported for output staging.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        last_d = (row_d == ROW_MAX) && (col_d == COL_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            last_q <= LAST_AT_ZERO;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            last_q <= last_d;
        end
    end

    assign last_o       = last_q;
    assign row_nxt_c_o  = row_d;
    assign col_nxt_c_o  = col_d;
    assign last_nxt_c_o = last_d;

endmodule

// File: rtl/matrix_result_streamer.sv
// Buffers one result matrix and streams it row-major over a valid/ready
// port with row/column tags; outputs are staged from next-state values.
module matrix_result_streamer
    import matrix_result_streamer_pkg::*;
#(
    parameter int unsigned M      = 2,
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_valid_i,
    output logic                         load_ready_o,
    input  logic [M*N*DATA_W-1:0]        load_data_i,
    input  logic                         abort_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_W-1:0]            out_data_o,
    output logic [idx_width(M)-1:0]      out_row_o,
    output logic [idx_width(N)-1:0]      out_col_o,
    output logic                         out_last_o,
    output logic                         busy_o
);

    localparam int unsigned RW    = idx_width(M);
    localparam int unsigned CW    = idx_width(N);
    localparam int unsigned ELEMS = M * N;

    stream_state_e               state_q, state_d;
    logic [M*N*DATA_W-1:0]       buf_q, buf_d;
    logic                        cnt_clr, cnt_en, cnt_last;
    logic [RW-1:0]               row_nxt;
    logic [CW-1:0]               col_nxt;
    logic                        last_nxt;

    logic                        out_valid_q, out_valid_d;
    logic [DATA_W-1:0]           out_data_q, out_data_d;
    logic [RW-1:0]               out_row_q, out_row_d;
    logic [CW-1:0]               out_col_q, out_col_d;
    logic                        out_last_q, out_last_d;
    logic                        load_ready_q, load_ready_d;
    logic                        busy_q, busy_d;
    logic [DATA_W-1:0]           elem;
    int unsigned                 flat_idx;

    matrix_index_counter #(
        .M  (M),
        .N  (N),
        .RW (RW),
        .CW (CW)
    ) u_index (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (cnt_clr),
        .en_i         (cnt_en),
        .last_o       (cnt_last),
        .row_nxt_c_o  (row_nxt),
        .col_nxt_c_o  (col_nxt),
        .last_nxt_c_o (last_nxt)
    );

    // Abort outranks out_ready; a beat handshaking alongside abort is delivered.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid_i) begin
                    buf_d   = load_data_i;
                    cnt_clr = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort_i) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (out_ready_i) begin
                    if (cnt_last) begin
                        cnt_clr = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage the element the next cycle will present; zero when not valid.
    always_comb begin
        flat_idx = 32'(row_nxt) * N + 32'(col_nxt);
        elem     = '0;
        for (int unsigned k = 0; k < ELEMS; k++) begin
            if (k == flat_idx) begin
                elem = buf_d[k*DATA_W +: DATA_W];
            end
        end
        out_valid_d  = (state_d == ST_STREAM);
        out_data_d   = out_valid_d ? elem     : '0;
        out_row_d    = out_valid_d ? row_nxt  : '0;
        out_col_d    = out_valid_d ? col_nxt  : '0;
        out_last_d   = out_valid_d ? last_nxt : 1'b0;
        load_ready_d = (state_d == ST_IDLE);
        busy_d       = out_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_row_q    <= '0;
            out_col_q    <= '0;
            out_last_q   <= 1'b0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_last_q   <= out_last_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_row_o    = out_row_q;
    assign out_col_o    = out_col_q;
    assign out_last_o   = out_last_q;
    assign load_ready_o = load_ready_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Drives 2x2, 3x2 and 1x1 streamers in lockstep and compares every cycle
// against a queue-of-beats model built from the loaded matrices.
module tb_matrix_result_streamer;

    typedef struct {
        logic [31:0] data;
        logic [31:0] row;
        logic [31:0] col;
        logic        last;
    } beat_t;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t mq[3][$];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid, abort, out_ready;
    logic [127:0] data4;
    logic [191:0] data6;
    logic [31:0]  data1;

    logic        lr4, ov4, ol4, busy4;
    logic [31:0] od4;
    logic [0:0]  orow4, ocol4;
    logic        lr6, ov6, ol6, busy6;
    logic [31:0] od6;
    logic [1:0]  orow6;
    logic [0:0]  ocol6;
    logic        lr1, ov1, ol1, busy1;
    logic [31:0] od1;
    logic [0:0]  orow1, ocol1;

    always #5 clk = ~clk;

    matrix_result_streamer #(.M(2), .N(2), .DATA_W(32)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid), .load_ready_o(lr4),
        .load_data_i(data4), .abort_i(abort), .out_valid_o(ov4), .out_ready_i(out_ready),
        .out_data_o(od4), .out_row_o(orow4), .out_col_o(ocol4), .out_last_o(ol4), .busy_o(busy4));

    matrix_result_streamer #(.M(3), .N(2), .DATA_W(32)) dut6 (
        .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid), .load_ready_o(lr6),
        .load_data_i(data6), .abort_i(abort), .out_valid_o(ov6), .out_ready_i(out_ready),
        .out_data_o(od6), .out_row_o(orow6), .out_col_o(ocol6), .out_last_o(ol6), .busy_o(busy6));

    matrix_result_streamer #(.M(1), .N(1), .DATA_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid_i(load_valid), .load_ready_o(lr1),
        .load_data_i(data1), .abort_i(abort), .out_valid_o(ov1), .out_ready_i(out_ready),
        .out_data_o(od1), .out_row_o(orow1), .out_col_o(ocol1), .out_last_o(ol1), .busy_o(busy1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_inst(input int i, input string nm, input logic v, input logic [31:0] d,
                              input logic [31:0] r, input logic [31:0] c, input logic l,
                              input logic rdy, input logic b);
        beat_t e;
        logic  act;
        act = (mq[i].size() != 0);
        e   = '{data: 32'd0, row: 32'd0, col: 32'd0, last: 1'b0};
        if (act) e = mq[i][0];
        chk({nm, ".out_valid"},  32'(v),   32'(act));
        chk({nm, ".out_data"},   d,        e.data);
        chk({nm, ".out_row"},    r,        e.row);
        chk({nm, ".out_col"},    c,        e.col);
        chk({nm, ".out_last"},   32'(l),   32'(e.last));
        chk({nm, ".load_ready"}, 32'(rdy), 32'(!act));
        chk({nm, ".busy"},       32'(b),   32'(act));
    endtask

    task automatic check_all();
        check_inst(0, "m2x2", ov4, od4, 32'(orow4), 32'(ocol4), ol4, lr4, busy4);
        check_inst(1, "m3x2", ov6, od6, 32'(orow6), 32'(ocol6), ol6, lr6, busy6);
        check_inst(2, "m1x1", ov1, od1, 32'(orow1), 32'(ocol1), ol1, lr1, busy1);
    endtask

    // Model of one clock edge: drain/abort a stream, or accept a whole matrix.
    task automatic model_edge(input int i, input int m, input int n, input logic [191:0] flat);
        beat_t b;
        if (mq[i].size() != 0) begin
            if (abort) mq[i].delete();
            else if (out_ready) void'(mq[i].pop_front());
        end else if (load_valid) begin
            for (int k = 0; k < m * n; k++) begin
                b.data = flat[k*32 +: 32];
                b.row  = 32'(k / n);
                b.col  = 32'(k % n);
                b.last = (k == m * n - 1);
                mq[i].push_back(b);
            end
        end
    endtask

    task automatic step(input logic lv, input logic ab, input logic rdy,
                        input logic [127:0] d4, input logic [191:0] d6, input logic [31:0] d1);
        @(negedge clk);
        check_all();
        load_valid = lv;
        abort      = ab;
        out_ready  = rdy;
        data4      = d4;
        data6      = d6;
        data1      = d1;
        model_edge(0, 2, 2, 192'(d4));
        model_edge(1, 3, 2, d6);
        model_edge(2, 1, 1, 192'(d1));
    endtask

    task automatic idle(input logic rdy, input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, rdy, '1, '1, '1);
    endtask

    logic [127:0] m1234, m5678, m9999;
    logic [191:0] m6a, m6b;
    logic [31:0]  mneg3;

    initial begin
        m1234 = {32'd4, 32'd3, 32'd2, 32'd1};
        m5678 = {32'd8, 32'd7, 32'd6, 32'd5};
        m9999 = {4{32'd9}};
        m6a   = {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11};
        m6b   = {6{32'd9}};
        mneg3 = 32'hFFFF_FFFD;
        rst_n = 1'b0;
        load_valid = 1'b1; abort = 1'b0; out_ready = 1'b1;
        data4 = m9999; data6 = m6b; data1 = 32'd7;

        // Reset values, with load_valid asserted to show it is ignored.
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        load_valid = 1'b0;

        // Free-flowing drain of [1,2,3,4]; 1x1 carries -3.
        step(1'b1, 1'b0, 1'b1, m1234, m6a, mneg3);
        idle(1'b1, 8);

        // Backpressure: element held for three cycles.
        step(1'b1, 1'b0, 1'b0, m5678, m6a, mneg3);
        idle(1'b0, 3);
        idle(1'b1, 8);

        // Load attempts mid-stream must not disturb the buffer.
        step(1'b1, 1'b0, 1'b1, m1234, m6a, mneg3);
        step(1'b1, 1'b0, 1'b1, m9999, m6b, 32'd9);
        step(1'b1, 1'b0, 1'b0, m9999, m6b, 32'd9);
        step(1'b0, 1'b0, 1'b1, m9999, m6b, 32'd9);
        idle(1'b1, 6);

        // Abort coinciding with the second handshake.
        step(1'b1, 1'b0, 1'b1, m1234, m6a, mneg3);
        step(1'b0, 1'b0, 1'b1, '0, '0, '0);
        step(1'b0, 1'b1, 1'b1, '0, '0, '0);
        idle(1'b1, 2);

        // Abort in idle does not block a simultaneous load.
        step(1'b1, 1'b1, 1'b1, m5678, m6a, mneg3);
        idle(1'b1, 8);

        // Asynchronous reset after two beats, then a clean restart.
        step(1'b1, 1'b0, 1'b1, m1234, m6a, mneg3);
        step(1'b0, 1'b0, 1'b1, '0, '0, '0);
        step(1'b0, 1'b0, 1'b1, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) mq[i].delete();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1, 3);
        step(1'b1, 1'b0, 1'b1, m1234, m6a, mneg3);
        idle(1'b1, 8);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 $urandom);
        end
        idle(1'b1, 10);
        @(negedge clk);
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
